led_scan_capture: RTL and testbench

//  Receiving end of the 8x8 RGB matrix scan interface (COMM row select + active-low DATA_R/G/B).

---
 rtl/led_scan_capture_pkg.sv | 30 +++
 rtl/led_scan_capture_scan_settle_filter.sv | 45 ++++
 rtl/led_scan_capture.sv | 156 +++++++++++++++
 tb/tb_led_scan_capture.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_capture_pkg.sv
// Shared definitions for the 8x8 RGB scan receiver: matrix geometry, scan word layout, FSM states.
package led_scan_capture_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 8;
    localparam int unsigned COMM_EN_BIT = 3;
    localparam int unsigned ROW_W       = $clog2(MATRIX_ROWS);

    typedef enum logic {
        HUNT,
        FILL
    } scan_state_t;

    typedef struct packed {
        logic [MATRIX_COLS-1:0] r;
        logic [MATRIX_COLS-1:0] g;
        logic [MATRIX_COLS-1:0] b;
    } rgb_row_t;

    typedef struct packed {
        logic [3:0] comm;
        rgb_row_t   data;
    } scan_word_t;

    // Scan lines drive LEDs active-low; everything stored internally is active-high.
    function automatic rgb_row_t to_active_high(input rgb_row_t d);
        return rgb_row_t'(~d);
    endfunction

endpackage

// File: rtl/led_scan_capture_scan_settle_filter.sv
// Synchronizes the raw scan word and emits one accept strobe per enabled word that stays stable.
module scan_settle_filter
    import led_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  scan_word_t raw,
    output scan_word_t word,
    output logic       accept
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES) + 1;

    scan_word_t    sync1;
    scan_word_t    sync2;
    logic [CW-1:0] cnt;
    logic          changed;

    assign changed = (sync2 != word);

    // The strobe fires only on the transition into the settled count, so a held word accepts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            word   <= '0;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            word   <= sync2;
            accept <= 1'b0;
            if (changed) begin
                cnt <= '0;
            end else if (cnt != CW'(SETTLE_CYCLES - 1)) begin
                cnt    <= cnt + CW'(1);
                accept <= (cnt == CW'(SETTLE_CYCLES - 2)) && word.comm[COMM_EN_BIT];
            end
        end
    end

endmodule

// File: rtl/led_scan_capture.sv
// Rebuilds complete 8x8 RGB frames from the row scan stream into a double-buffered store.
module led_scan_capture
    import led_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] COMM,
    input  logic [7:0] DATA_R,
    input  logic [7:0] DATA_G,
    input  logic [7:0] DATA_B,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_r,
    output logic [7:0] rd_g,
    output logic [7:0] rd_b,
    output logic       frame_valid,
    output logic [7:0] frame_count,
    output logic       seq_err,
    output logic       scan_lost
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    scan_word_t       raw;
    scan_word_t       word;
    logic             accept;
    logic [ROW_W-1:0] row;
    rgb_row_t         row_data;

    scan_state_t      state;
    scan_state_t      state_d;
    logic [ROW_W-1:0] exp_row;
    logic [ROW_W-1:0] exp_d;
    logic             store;
    logic             swap;
    logic             err;

    logic [TW-1:0]    tcnt;
    logic             timeout_hit;

    rgb_row_t         shadow [MATRIX_ROWS];
    rgb_row_t         disp   [MATRIX_ROWS];
    rgb_row_t         disp_d [MATRIX_ROWS];

    assign raw = {COMM, DATA_R, DATA_G, DATA_B};

    scan_settle_filter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk   (CLK),
        .rst   (RST),
        .raw   (raw),
        .word  (word),
        .accept(accept)
    );

    assign row         = word.comm[ROW_W-1:0];
    assign row_data    = to_active_high(word.data);
    assign timeout_hit = !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state;
        exp_d   = exp_row;
        store   = 1'b0;
        swap    = 1'b0;
        err     = 1'b0;
        if (accept) begin
            unique case (state)
                HUNT: begin
                    if (row == '0) begin
                        store   = 1'b1;
                        exp_d   = ROW_W'(1);
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (row == exp_row) begin
                        store = 1'b1;
                        exp_d = exp_row + ROW_W'(1);
                        if (row == ROW_W'(MATRIX_ROWS - 1)) begin
                            swap    = 1'b1;
                            state_d = HUNT;
                        end
                    end else begin
                        err = 1'b1;
                        if (row == '0) begin
                            store = 1'b1;
                            exp_d = ROW_W'(1);
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (timeout_hit) begin
            state_d = HUNT;
        end
    end

    // The last row bypasses the shadow on swap so the read port sees the whole frame in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < MATRIX_ROWS; i++) begin
            disp_d[i] = disp[i];
            if (swap) begin
                disp_d[i] = (ROW_W'(i) == row) ? row_data : shadow[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= HUNT;
            exp_row     <= '0;
            tcnt        <= '0;
            scan_lost   <= 1'b0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            frame_count <= '0;
            rd_r        <= '0;
            rd_g        <= '0;
            rd_b        <= '0;
            for (int unsigned i = 0; i < MATRIX_ROWS; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            state       <= state_d;
            exp_row     <= exp_d;
            frame_valid <= swap;
            seq_err     <= err;
            if (swap) begin
                frame_count <= frame_count + 8'd1;
            end
            if (store) begin
                shadow[row] <= row_data;
            end
            for (int unsigned i = 0; i < MATRIX_ROWS; i++) begin
                disp[i] <= disp_d[i];
            end
            {rd_r, rd_g, rd_b} <= disp_d[rd_row];
            if (accept) begin
                tcnt      <= '0;
                scan_lost <= 1'b0;
            end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + TW'(1);
                if (timeout_hit) begin
                    scan_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_capture.sv
// Self-checking bench for led_scan_capture: vector table, corner sequences, random scan stream vs frame model.
module tb_led_scan_capture;

    localparam int S = 16;
    localparam int T = 500;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] COMM;
    logic [7:0] DATA_R, DATA_G, DATA_B;
    logic [2:0] rd_row;
    logic [7:0] rd_r, rd_g, rd_b;
    logic       frame_valid;
    logic [7:0] frame_count;
    logic       seq_err;
    logic       scan_lost;

    always #5 CLK = ~CLK;

    led_scan_capture #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .COMM       (COMM),
        .DATA_R     (DATA_R),
        .DATA_G     (DATA_G),
        .DATA_B     (DATA_B),
        .rd_row     (rd_row),
        .rd_r       (rd_r),
        .rd_g       (rd_g),
        .rd_b       (rd_b),
        .frame_valid(frame_valid),
        .frame_count(frame_count),
        .seq_err    (seq_err),
        .scan_lost  (scan_lost)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fv_seen  = 0;
    int err_seen = 0;

    always @(negedge CLK) begin
        if (frame_valid) fv_seen++;
        if (seq_err) err_seen++;
    end

    // Reference model: the frame under construction is a queue of accepted rows.
    logic [23:0] m_q[$];
    logic [23:0] m_disp[8];
    int          m_fv = 0;
    int          m_err = 0;
    logic [7:0]  m_fcount = '0;
    logic [27:0] m_last = '0;

    function automatic void model_accept(input int row, input logic [23:0] act);
        if (m_q.size() == 0) begin
            if (row == 0) m_q.push_back(act);
        end else if (row == m_q.size()) begin
            m_q.push_back(act);
            if (m_q.size() == 8) begin
                for (int i = 0; i < 8; i++) m_disp[i] = m_q[i];
                m_fv++;
                m_fcount++;
                m_q.delete();
            end
        end else begin
            m_err++;
            m_q.delete();
            if (row == 0) m_q.push_back(act);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_disp[i] = '0;
        m_fcount = '0;
        m_last   = '0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input bit en, input int row, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        COMM   = {en, 3'(row)};
        DATA_R = r;
        DATA_G = g;
        DATA_B = b;
    endtask

    task automatic drive_word(input bit en, input int row, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input int hold);
        logic [27:0] w;
        set_word(en, row, r, g, b);
        w = {en, 3'(row), r, g, b};
        step(hold);
        if (en && (w != m_last)) model_accept(row, ~{r, g, b});
        m_last = w;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " frame_valid pulses"}, fv_seen, m_fv);
        check({tag, " seq_err pulses"}, err_seen, m_err);
        check({tag, " frame_count"}, frame_count, m_fcount);
    endtask

    task automatic check_display(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            step(1);
            check($sformatf("%s rd row %0d", tag, i), {rd_r, rd_g, rd_b}, m_disp[i]);
        end
    endtask

    task automatic send_frame(input int hold, input bit rnd);
        logic [7:0] r, g, b;
        for (int i = 0; i < 8; i++) begin
            r = rnd ? 8'($urandom) : 8'(~(8'd1 << i));
            g = rnd ? 8'($urandom) : 8'(8'h11 * i);
            b = rnd ? 8'($urandom) : 8'h5A;
            drive_word(1'b1, i, r, g, b, hold);
        end
    endtask

    typedef struct {
        bit         en;
        int         row;
        logic [7:0] r;
        int         exp_fv;
        int         exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        int fv0, e0, k;
        logic [7:0] rr;

        RST = 1'b1;
        set_word(1'b0, 0, 8'h00, 8'h00, 8'h00);
        rd_row = '0;
        model_reset();
        step(3);
        check("reset rd", {rd_r, rd_g, rd_b}, 24'h0);
        check("reset frame_count", frame_count, 0);
        check("reset flags", {frame_valid, seq_err, scan_lost}, 3'b000);
        RST = 1'b0;
        step(2);

        // Clean frame, skip, duplicate
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, i, 8'(~(8'd1 << i)), (i == 7) ? 1 : 0, 0});
        tbl.push_back('{1'b1, 0, 8'hC0, 0, 0});
        tbl.push_back('{1'b1, 1, 8'hC1, 0, 0});
        tbl.push_back('{1'b1, 3, 8'hC3, 0, 1});
        tbl.push_back('{1'b1, 5, 8'hC5, 0, 0});
        tbl.push_back('{1'b1, 0, 8'hD0, 0, 0});
        tbl.push_back('{1'b1, 1, 8'hD1, 0, 0});
        tbl.push_back('{1'b0, 0, 8'hFF, 0, 0});
        tbl.push_back('{1'b1, 1, 8'hD1, 0, 1});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, i, 8'(8'hE0 + i), (i == 7) ? 1 : 0, 0});

        foreach (tbl[n]) begin
            fv0 = fv_seen;
            e0  = err_seen;
            drive_word(tbl[n].en, tbl[n].row, tbl[n].r, 8'({4'(tbl[n].row), 4'hA}), 8'h55 ^ tbl[n].r, 40);
            check($sformatf("vec %0d frame_valid", n), fv_seen - fv0, tbl[n].exp_fv);
            check($sformatf("vec %0d seq_err", n), err_seen - e0, tbl[n].exp_err);
            if (n == 7) begin
                rd_row = 3'd0;
                step(1);
                check("clean frame rd_r row0", rd_r, 8'h01);
                check_display("clean");
            end
            if (n == 11) check_display("after skip");
        end
        check_counts("table");
        check_display("after dup");

        // Glitching row 2 must produce a single accept
        drive_word(1'b1, 0, 8'h10, 8'h20, 8'h30, 40);
        drive_word(1'b1, 1, 8'h11, 8'h21, 8'h31, 40);
        e0 = err_seen;
        for (int t = 0; t < 13; t++) begin
            set_word(1'b1, 2, (t % 2 == 0) ? 8'h12 : 8'h34, 8'h22, 8'h32);
            step(8);
        end
        drive_word(1'b1, 2, 8'h34, 8'h22, 8'h32, 40);
        check("glitch seq_err", err_seen - e0, 0);
        fv0 = fv_seen;
        for (int i = 3; i < 8; i++) drive_word(1'b1, i, 8'(8'h10 + i), 8'h23, 8'h33, 40);
        check("glitch frame_valid", fv_seen - fv0, 1);
        check_display("glitch");
        check_counts("glitch");

        // Latency from last row change to frame_valid
        for (int i = 0; i < 7; i++) drive_word(1'b1, i, 8'(8'h70 + i), 8'h71, 8'h72, 40);
        set_word(1'b1, 7, 8'h77, 8'h71, 8'h72);
        k = 0;
        while (!frame_valid && k < 100) begin
            step(1);
            k++;
        end
        check("row7 to frame_valid latency", k, S + 3);
        drive_word(1'b1, 7, 8'h77, 8'h71, 8'h72, 40 - k);
        check_counts("latency");

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) drive_word(1'b1, i, 8'(8'h40 + i), 8'h41, 8'h42, 40);
        drive_word(1'b0, 0, 8'hFF, 8'hFF, 8'hFF, 4);
        RST = 1'b1;
        #1;
        check("async reset rd", {rd_r, rd_g, rd_b}, 24'h0);
        check("async reset frame_count", frame_count, 0);
        step(2);
        RST = 1'b0;
        model_reset();
        check_display("post reset");
        fv0 = fv_seen;
        e0  = err_seen;
        for (int i = 4; i < 8; i++) drive_word(1'b1, i, 8'(8'h40 + i), 8'h43, 8'h44, 40);
        check("reset tail rows frame_valid", fv_seen - fv0, 0);
        check("reset tail rows seq_err", err_seen - e0, 0);
        send_frame(40, 1'b0);
        check("post reset frame_count", frame_count, 1);
        check_display("post reset frame");
        check_counts("reset");

        // Scan stops after row 4
        for (int i = 0; i < 4; i++) drive_word(1'b1, i, 8'(8'h60 + i), 8'h61, 8'h62, 40);
        check("scan_lost before stop", scan_lost, 0);
        set_word(1'b1, 4, 8'h64, 8'h61, 8'h62);
        k = 0;
        while (!scan_lost && k < 2000) begin
            step(1);
            k++;
        end
        check("scan_lost onset", k, S + 3 + T);
        model_accept(4, ~{8'h64, 8'h61, 8'h62});
        m_last = {4'hC, 8'h64, 8'h61, 8'h62};
        m_q.delete();
        step(20);
        check("scan_lost holds", scan_lost, 1);
        set_word(1'b1, 5, 8'h65, 8'h61, 8'h62);
        k = 0;
        while (scan_lost && k < 200) begin
            step(1);
            k++;
        end
        check("scan_lost clear", k, S + 3);
        drive_word(1'b1, 5, 8'h65, 8'h61, 8'h62, 40 - k);
        fv0 = fv_seen;
        e0  = err_seen;
        drive_word(1'b1, 6, 8'h66, 8'h61, 8'h62, 40);
        drive_word(1'b1, 7, 8'h67, 8'h61, 8'h62, 40);
        check("timeout discards partial frame", fv_seen - fv0, 0);
        check("timeout then HUNT no seq_err", err_seen - e0, 0);
        check_counts("timeout");
        check_display("timeout");

        // Random scan stream
        for (int n = 0; n < 150; n++) begin
            int row;
            bit en;
            en  = ($urandom_range(7) != 0);
            row = ($urandom_range(1) == 0) ? (m_q.size() % 8) : int'($urandom_range(7));
            rr  = 8'($urandom);
            drive_word(en, row, rr, 8'($urandom), 8'($urandom), $urandom_range(24, 40));
            if (n % 10 == 9) check_counts($sformatf("random %0d", n));
        end
        check("random scan_lost", scan_lost, 0);
        check_display("random");

        // frame_count wraps 255 -> 0
        drive_word(1'b0, 0, 8'h00, 8'h00, 8'h00, 20);
        m_q.delete();
        while (m_fcount != 8'd2) begin
            send_frame(20, 1'b1);
            check("wrap frame_count", frame_count, m_fcount);
        end
        check_counts("wrap");
        check_display("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
